// File: rtl/st7735_spi_rx_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : st7735_spi_rx_model_if
//  Description : Bundle of the ST7735 4-wire SPI pins and the decoded panel
//                outputs of st7735_spi_rx_model.
//                master : drives the SPI pins and observes the decoded outputs
//                slave  : the receiver model (samples the pins, drives outputs)
//  Signals     : spi_cs_n/spi_sck/spi_mosi/spi_dc  - SPI pins (async to clk)
//                rx_valid/rx_is_data/rx_byte      - received byte strobe
//                pix_valid/pix_x/pix_y/pix_rgb    - pixel write strobe
//                sleep_out/disp_on/colmod/madctl  - tracked panel state
//                proto_err                        - protocol error pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface st7735_spi_rx_model_if;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_dc;
    logic        rx_valid;
    logic        rx_is_data;
    logic [7:0]  rx_byte;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] pix_rgb;
    logic        sleep_out;
    logic        disp_on;
    logic [7:0]  colmod;
    logic [7:0]  madctl;
    logic        proto_err;

    modport master (
        output spi_cs_n, spi_sck, spi_mosi, spi_dc,
        input  rx_valid, rx_is_data, rx_byte,
        input  pix_valid, pix_x, pix_y, pix_rgb,
        input  sleep_out, disp_on, colmod, madctl, proto_err
    );

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi, spi_dc,
        output rx_valid, rx_is_data, rx_byte,
        output pix_valid, pix_x, pix_y, pix_rgb,
        output sleep_out, disp_on, colmod, madctl, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/st7735_spi_rx_model.sv
`default_nettype none
// ============================================================================
//  Module      : st7735_spi_rx_model
//  Description : Receiving end of the ST7735 4-wire SPI link. Oversamples
//                CSX/SCL/SDA/DC on clk, assembles MSB-first bytes, decodes
//                the init command subset (SWRESET, SLPOUT, DISPOFF, DISPON,
//                COLMOD, MADCTL, CASET, RASET, RAMWR, NOP), tracks panel
//                state and emits one strobe per RGB565 pixel with its x/y.
//  Ports       : clk, rst      - system clock, synchronous active-high reset
//                bus (slave)   - SPI pins in; rx_*, pix_*, panel state and
//                                proto_err out (see st7735_spi_rx_model_if)
//  Parameters  : SYNC_STAGES (>=2), WIDTH, HEIGHT (default window extent)
//  Revision    : 1.0 - initial release
// ============================================================================
module st7735_spi_rx_model #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 160
) (
    input  wire logic             clk,
    input  wire logic             rst,
    st7735_spi_rx_model_if.slave  bus
);

    localparam logic [7:0] c_xe_rst      = 8'(WIDTH - 1);
    localparam logic [7:0] c_ye_rst      = 8'(HEIGHT - 1);
    localparam logic [7:0] c_colmod_rst  = 8'h06;
    localparam logic [7:0] c_cmd_nop     = 8'h00;
    localparam logic [7:0] c_cmd_swreset = 8'h01;
    localparam logic [7:0] c_cmd_slpout  = 8'h11;
    localparam logic [7:0] c_cmd_dispoff = 8'h28;
    localparam logic [7:0] c_cmd_dispon  = 8'h29;
    localparam logic [7:0] c_cmd_caset   = 8'h2A;
    localparam logic [7:0] c_cmd_raset   = 8'h2B;
    localparam logic [7:0] c_cmd_ramwr   = 8'h2C;
    localparam logic [7:0] c_cmd_madctl  = 8'h36;
    localparam logic [7:0] c_cmd_colmod  = 8'h3A;

    typedef enum logic [2:0] {
        ST_CMD      = 3'd0,
        ST_ARG1     = 3'd1,
        ST_WIN      = 3'd2,  // CASET / RASET, four argument bytes
        ST_RAMWR_HI = 3'd3,
        ST_RAMWR_LO = 3'd4,
        ST_SKIP     = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers. CS and SCK chains reset to 1 so that a pin that
    // is already high when reset releases never looks like a fresh edge
    // or a selected bus.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic                   r_sck_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '1;
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
            r_sck_prev  <= 1'b1;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_n};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  bus.spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   bus.spi_dc};
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs_n;
    logic w_sck;
    logic w_mosi;
    logic w_dc;
    logic w_sck_rise;

    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_dc       = r_dc_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;

    // ------------------------------------------------------------------
    // Byte assembly. Only 7 bits need storing: the 8th bit goes straight
    // into rx_byte together with the DC level of that final edge.
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shreg;
    logic       r_rx_valid;
    logic       r_rx_is_data;
    logic [7:0] r_rx_byte;
    logic       r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= 3'd0;
            r_shreg      <= 7'd0;
            r_rx_valid   <= 1'b0;
            r_rx_is_data <= 1'b0;
            r_rx_byte    <= 8'd0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_n) begin
                // A nonzero count here means the frame ended mid-byte.
                r_bit_cnt   <= 3'd0;
                r_frame_err <= (r_bit_cnt != 3'd0);
            end else if (w_sck_rise) begin
                r_shreg   <= {r_shreg[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_valid   <= 1'b1;
                    r_rx_byte    <= {r_shreg, w_mosi};
                    r_rx_is_data <= w_dc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decoder: state register plus all decoder-owned registers.
    // ------------------------------------------------------------------
    state_t      r_state,     w_state_nxt;
    logic        r_sleep,     w_sleep_nxt;
    logic        r_disp,      w_disp_nxt;
    logic [7:0]  r_colmod,    w_colmod_nxt;
    logic [7:0]  r_madctl,    w_madctl_nxt;
    logic [7:0]  r_xs,        w_xs_nxt;
    logic [7:0]  r_xe,        w_xe_nxt;
    logic [7:0]  r_ys,        w_ys_nxt;
    logic [7:0]  r_ye,        w_ye_nxt;
    logic [7:0]  r_cur_x,     w_cur_x_nxt;
    logic [7:0]  r_cur_y,     w_cur_y_nxt;
    logic [7:0]  r_hi_byte,   w_hi_byte_nxt;
    logic        r_win_bad,   w_win_bad_nxt;   // RAMWR window was inverted
    logic [1:0]  r_arg_idx,   w_arg_idx_nxt;
    logic        r_win_row,   w_win_row_nxt;   // 1: RASET, 0: CASET
    logic        r_arg_mad,   w_arg_mad_nxt;   // 1: MADCTL, 0: COLMOD
    logic [7:0]  r_pix_x,     w_pix_x_nxt;
    logic [7:0]  r_pix_y,     w_pix_y_nxt;
    logic [15:0] r_pix_rgb,   w_pix_rgb_nxt;
    logic        r_pix_valid, w_pix_valid;
    logic        r_proto_err, w_dec_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CMD;
            r_sleep     <= 1'b0;
            r_disp      <= 1'b0;
            r_colmod    <= c_colmod_rst;
            r_madctl    <= 8'h00;
            r_xs        <= 8'd0;
            r_xe        <= c_xe_rst;
            r_ys        <= 8'd0;
            r_ye        <= c_ye_rst;
            r_cur_x     <= 8'd0;
            r_cur_y     <= 8'd0;
            r_hi_byte   <= 8'd0;
            r_win_bad   <= 1'b0;
            r_arg_idx   <= 2'd0;
            r_win_row   <= 1'b0;
            r_arg_mad   <= 1'b0;
            r_pix_x     <= 8'd0;
            r_pix_y     <= 8'd0;
            r_pix_rgb   <= 16'd0;
            r_pix_valid <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sleep     <= w_sleep_nxt;
            r_disp      <= w_disp_nxt;
            r_colmod    <= w_colmod_nxt;
            r_madctl    <= w_madctl_nxt;
            r_xs        <= w_xs_nxt;
            r_xe        <= w_xe_nxt;
            r_ys        <= w_ys_nxt;
            r_ye        <= w_ye_nxt;
            r_cur_x     <= w_cur_x_nxt;
            r_cur_y     <= w_cur_y_nxt;
            r_hi_byte   <= w_hi_byte_nxt;
            r_win_bad   <= w_win_bad_nxt;
            r_arg_idx   <= w_arg_idx_nxt;
            r_win_row   <= w_win_row_nxt;
            r_arg_mad   <= w_arg_mad_nxt;
            r_pix_x     <= w_pix_x_nxt;
            r_pix_y     <= w_pix_y_nxt;
            r_pix_rgb   <= w_pix_rgb_nxt;
            r_pix_valid <= w_pix_valid;
            r_proto_err <= w_dec_err | r_frame_err;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sleep_nxt   = r_sleep;
        w_disp_nxt    = r_disp;
        w_colmod_nxt  = r_colmod;
        w_madctl_nxt  = r_madctl;
        w_xs_nxt      = r_xs;
        w_xe_nxt      = r_xe;
        w_ys_nxt      = r_ys;
        w_ye_nxt      = r_ye;
        w_cur_x_nxt   = r_cur_x;
        w_cur_y_nxt   = r_cur_y;
        w_hi_byte_nxt = r_hi_byte;
        w_win_bad_nxt = r_win_bad;
        w_arg_idx_nxt = r_arg_idx;
        w_win_row_nxt = r_win_row;
        w_arg_mad_nxt = r_arg_mad;
        w_pix_x_nxt   = r_pix_x;
        w_pix_y_nxt   = r_pix_y;
        w_pix_rgb_nxt = r_pix_rgb;
        w_pix_valid   = 1'b0;
        w_dec_err     = 1'b0;

        if (r_rx_valid) begin
            if (!r_rx_is_data) begin
                // A command always aborts whatever was in progress. Only
                // commands with mandatory arguments still outstanding are
                // errors; an abandoned RAMWR stream is legal.
                w_dec_err   = (r_state == ST_ARG1) || (r_state == ST_WIN);
                w_state_nxt = ST_CMD;
                case (r_rx_byte)
                    c_cmd_nop: ;
                    c_cmd_swreset: begin
                        w_sleep_nxt   = 1'b0;
                        w_disp_nxt    = 1'b0;
                        w_colmod_nxt  = c_colmod_rst;
                        w_madctl_nxt  = 8'h00;
                        w_xs_nxt      = 8'd0;
                        w_xe_nxt      = c_xe_rst;
                        w_ys_nxt      = 8'd0;
                        w_ye_nxt      = c_ye_rst;
                        w_cur_x_nxt   = 8'd0;
                        w_cur_y_nxt   = 8'd0;
                        w_hi_byte_nxt = 8'd0;
                        w_win_bad_nxt = 1'b0;
                        w_arg_idx_nxt = 2'd0;
                        w_pix_x_nxt   = 8'd0;
                        w_pix_y_nxt   = 8'd0;
                        w_pix_rgb_nxt = 16'd0;
                    end
                    c_cmd_slpout:  w_sleep_nxt = 1'b1;
                    c_cmd_dispoff: w_disp_nxt  = 1'b0;
                    c_cmd_dispon:  w_disp_nxt  = 1'b1;
                    c_cmd_colmod: begin
                        w_state_nxt   = ST_ARG1;
                        w_arg_mad_nxt = 1'b0;
                    end
                    c_cmd_madctl: begin
                        w_state_nxt   = ST_ARG1;
                        w_arg_mad_nxt = 1'b1;
                    end
                    c_cmd_caset, c_cmd_raset: begin
                        w_state_nxt   = ST_WIN;
                        w_win_row_nxt = (r_rx_byte == c_cmd_raset);
                        w_arg_idx_nxt = 2'd0;
                    end
                    c_cmd_ramwr: begin
                        w_state_nxt   = ST_RAMWR_HI;
                        w_cur_x_nxt   = r_xs;
                        w_cur_y_nxt   = r_ys;
                        w_win_bad_nxt = (r_xs > r_xe) || (r_ys > r_ye);
                        if ((r_xs > r_xe) || (r_ys > r_ye)) begin
                            w_dec_err = 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_SKIP;
                endcase
            end else begin
                case (r_state)
                    ST_CMD: w_dec_err = 1'b1;
                    ST_ARG1: begin
                        if (r_arg_mad) begin
                            w_madctl_nxt = r_rx_byte;
                        end else begin
                            w_colmod_nxt = r_rx_byte;
                        end
                        w_state_nxt = ST_CMD;
                    end
                    ST_WIN: begin
                        // Index 0/2 are the high address bytes: the panel is
                        // at most 255 wide, so nonzero is flagged and ignored.
                        w_arg_idx_nxt = r_arg_idx + 2'd1;
                        case (r_arg_idx)
                            2'd1: begin
                                if (r_win_row) w_ys_nxt = r_rx_byte;
                                else           w_xs_nxt = r_rx_byte;
                            end
                            2'd3: begin
                                if (r_win_row) w_ye_nxt = r_rx_byte;
                                else           w_xe_nxt = r_rx_byte;
                                w_state_nxt = ST_CMD;
                            end
                            default: w_dec_err = (r_rx_byte != 8'h00);
                        endcase
                    end
                    ST_RAMWR_HI: begin
                        w_hi_byte_nxt = r_rx_byte;
                        w_state_nxt   = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        w_state_nxt = ST_RAMWR_HI;
                        if (!r_win_bad) begin
                            w_pix_valid   = 1'b1;
                            w_pix_x_nxt   = r_cur_x;
                            w_pix_y_nxt   = r_cur_y;
                            w_pix_rgb_nxt = {r_hi_byte, r_rx_byte};
                            if (r_cur_x == r_xe) begin
                                w_cur_x_nxt = r_xs;
                                w_cur_y_nxt = (r_cur_y == r_ye) ? r_ys : r_cur_y + 8'd1;
                            end else begin
                                w_cur_x_nxt = r_cur_x + 8'd1;
                            end
                        end
                    end
                    ST_SKIP: ;
                    default: w_state_nxt = ST_CMD;
                endcase
            end
        end
    end

    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_is_data = r_rx_is_data;
    assign bus.rx_byte    = r_rx_byte;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_x      = r_pix_x;
    assign bus.pix_y      = r_pix_y;
    assign bus.pix_rgb    = r_pix_rgb;
    assign bus.sleep_out  = r_sleep;
    assign bus.disp_on    = r_disp;
    assign bus.colmod     = r_colmod;
    assign bus.madctl     = r_madctl;
    assign bus.proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_st7735_spi_rx_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_st7735_spi_rx_model
//  Description : Self-checking bench for st7735_spi_rx_model. Drives SPI
//                bytes at clk/8, predicts received bytes and pixels into
//                queues that a monitor pops, and checks panel state and the
//                proto_err count against a byte table and corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_st7735_spi_rx_model;

    logic clk;
    logic rst;

    st7735_spi_rx_model_if bus();

    st7735_spi_rx_model #(
        .SYNC_STAGES (2),
        .WIDTH       (128),
        .HEIGHT      (160)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
    } rx_t;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic       sleep;
        logic       disp;
        logic [7:0] colmod;
        logic [7:0] madctl;
        int         errs;
    } vec_t;

    rx_t          q_rx[$];
    logic [31:0]  q_pix[$];
    vec_t         tbl[$];
    int           n_vec;
    int           n_fail;
    int           err_seen;

    // Monitor: every byte/pixel strobe must match the head of its queue.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_vec++;
            if (q_rx.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: got dc=%0d byte=%h, required none", bus.rx_is_data, bus.rx_byte);
            end else begin
                rx_t e;
                e = q_rx.pop_front();
                if ({bus.rx_is_data, bus.rx_byte} !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte: got dc=%0d byte=%h, required dc=%0d byte=%h", bus.rx_is_data, bus.rx_byte, e.dc, e.b);
                end
            end
        end
        if (bus.pix_valid) begin
            n_vec++;
            if (q_pix.size() == 0) begin
                n_fail++;
                $display("FAIL pix_unexpected: got (%0d,%0d) %h, required none", bus.pix_x, bus.pix_y, bus.pix_rgb);
            end else begin
                logic [31:0] p;
                p = q_pix.pop_front();
                if ({bus.pix_x, bus.pix_y, bus.pix_rgb} !== p) begin
                    n_fail++;
                    $display("FAIL pixel: got (%0d,%0d) %h, required (%0d,%0d) %h", bus.pix_x, bus.pix_y, bus.pix_rgb, p[31:24], p[23:16], p[15:0]);
                end
            end
        end
        if (bus.proto_err) err_seen++;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Shift nbits of data MSB first (SPI mode 0, 8 clk per SCL period).
    task automatic send_bits(input logic dc, input logic [7:0] data, input int nbits);
        if (nbits == 8) q_rx.push_back({dc, data});
        if (bus.spi_cs_n) begin
            bus.spi_cs_n = 1'b0;
            clocks(4);
        end
        bus.spi_dc = dc;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = data[i];
            clocks(4);
            bus.spi_sck = 1'b1;
            clocks(4);
        end
        bus.spi_sck = 1'b0;
        clocks(2);
    endtask

    task automatic cs_release();
        bus.spi_cs_n = 1'b1;
        clocks(10);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q_rx.size() != 0 || q_pix.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes %0d pixels pending, required 0", q_rx.size(), q_pix.size());
            q_rx.delete();
            q_pix.delete();
        end
        clocks(6);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic check_state(input string nm, input logic sl, input logic dp,
                               input logic [7:0] cm, input logic [7:0] md);
        check(nm, {bus.sleep_out, bus.disp_on, bus.colmod, bus.madctl}, {sl, dp, cm, md});
    endtask

    task automatic check_reset_outputs(input string nm);
        check(nm,
              {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb, bus.rx_valid, bus.rx_is_data,
               bus.rx_byte, bus.sleep_out, bus.disp_on, bus.colmod, bus.madctl, bus.proto_err},
              {1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 8'h00, 1'b0});
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        err_seen = 0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_dc   = 1'b0;
        rst = 1'b1;

        // dc, byte, expected sleep, disp, colmod, madctl, cumulative errors
        tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 8'h06, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h11, 1'b1, 1'b0, 8'h06, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h3A, 1'b1, 1'b0, 8'h06, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h05, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h36, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h2A, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h7F, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h2B, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h9F, 1'b1, 1'b0, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h29, 1'b1, 1'b1, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b0, 8'h36, 1'b1, 1'b1, 8'h05, 8'h00, 0});
        tbl.push_back('{1'b1, 8'h60, 1'b1, 1'b1, 8'h05, 8'h60, 0});
        tbl.push_back('{1'b1, 8'hAA, 1'b1, 1'b1, 8'h05, 8'h60, 1});  // data in CMD
        tbl.push_back('{1'b0, 8'hB1, 1'b1, 1'b1, 8'h05, 8'h60, 1});  // unknown cmd
        tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 8'h05, 8'h60, 1});
        tbl.push_back('{1'b1, 8'h2C, 1'b1, 1'b1, 8'h05, 8'h60, 1});
        tbl.push_back('{1'b1, 8'h28, 1'b1, 1'b1, 8'h05, 8'h60, 1});
        tbl.push_back('{1'b0, 8'h3A, 1'b1, 1'b1, 8'h05, 8'h60, 1});
        tbl.push_back('{1'b0, 8'h11, 1'b1, 1'b1, 8'h05, 8'h60, 2});  // COLMOD arg missing
        tbl.push_back('{1'b0, 8'h28, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b0, 8'h2A, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h02, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h03, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b0, 8'h2B, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h05, 1'b1, 1'b0, 8'h05, 8'h60, 2});
        tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b0, 8'h05, 8'h60, 3});  // nonzero hi
        tbl.push_back('{1'b1, 8'h06, 1'b1, 1'b0, 8'h05, 8'h60, 3});

        clocks(5);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_state");

        for (int i = 0; i < tbl.size(); i++) begin
            send_bits(tbl[i].dc, tbl[i].data, 8);
            wait_drain();
            check_state($sformatf("state_v%0d", i), tbl[i].sleep, tbl[i].disp, tbl[i].colmod, tbl[i].madctl);
            check($sformatf("errs_v%0d", i), 64'(err_seen), 64'(tbl[i].errs));
        end

        // RAMWR into window x 2..3, y 5..6 with wrap back to the origin.
        cmd(8'h2C);
        q_pix.push_back({8'd2, 8'd5, 16'hF800}); dat(8'hF8); dat(8'h00);
        q_pix.push_back({8'd3, 8'd5, 16'h07E0}); dat(8'h07); dat(8'hE0);
        q_pix.push_back({8'd2, 8'd6, 16'h001F}); dat(8'h00); dat(8'h1F);
        q_pix.push_back({8'd3, 8'd6, 16'h1234}); dat(8'h12); dat(8'h34);
        q_pix.push_back({8'd2, 8'd5, 16'hABCD}); dat(8'hAB); dat(8'hCD);
        wait_drain();
        check("ramwr_last_rgb", {bus.pix_x, bus.pix_y, bus.pix_rgb}, {8'd2, 8'd5, 16'hABCD});
        check("ramwr_errs", 64'(err_seen), 64'd3);

        // Partial byte dropped at CS rise, then a full DISPON decodes.
        send_bits(1'b0, 8'hFF, 5);
        cs_release();
        wait_drain();
        check("partial_errs", 64'(err_seen), 64'd4);
        cmd(8'h29);
        wait_drain();
        check_state("after_partial", 1'b1, 1'b1, 8'h05, 8'h60);

        // Command aborts a RAMWR with a pending high byte: no error, back in CMD.
        cmd(8'h2C); dat(8'h12); cmd(8'h00);
        wait_drain();
        check("abort_errs", 64'(err_seen), 64'd4);
        dat(8'h55);
        wait_drain();
        check("abort_in_cmd", 64'(err_seen), 64'd5);

        // Inverted column window: error at RAMWR, pixels consumed silently.
        cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h05);
        cmd(8'h2C); dat(8'h11); dat(8'h22);
        wait_drain();
        check("badwin_errs", 64'(err_seen), 64'd6);

        // SWRESET restores panel state and full-screen window.
        cmd(8'h01);
        wait_drain();
        check_state("swreset_state", 1'b0, 1'b0, 8'h06, 8'h00);
        cmd(8'h2C);
        q_pix.push_back({8'd0, 8'd0, 16'hBEEF}); dat(8'hBE); dat(8'hEF);
        q_pix.push_back({8'd1, 8'd0, 16'h0102}); dat(8'h01); dat(8'h02);
        wait_drain();
        check("swreset_errs", 64'(err_seen), 64'd6);

        // Reset in the middle of a RAMWR high byte and a partial bit stream.
        cmd(8'h11); cmd(8'h2C); dat(8'h77);
        wait_drain();
        send_bits(1'b1, 8'hE0, 3);
        rst = 1'b1;
        clocks(2);
        @(negedge clk);
        check_reset_outputs("midrst_state");
        rst = 1'b0;
        cs_release();
        wait_drain();
        check("midrst_errs", 64'(err_seen), 64'd6);
        cmd(8'h29); cmd(8'h2C);
        q_pix.push_back({8'd0, 8'd0, 16'h5A5A}); dat(8'h5A); dat(8'h5A);
        wait_drain();
        check_state("midrst_after", 1'b0, 1'b1, 8'h06, 8'h00);
        check("midrst_final_errs", 64'(err_seen), 64'd6);
        cs_release();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
